mul_seq_8bits: RTL and testbench

Sequential signed 8x8 shift-add multiplier for the calculator datapath. Sits directly downstream of the operand complement stage: it takes the two's-complement 8-bit operands that stage produces and returns a 16-bit signed product, plus an 8-bit overflow flag, to the result/display path. Uses a start/busy/done handshake driven by the calculator control FSM.

---
 rtl/calc_pkg.sv | 17 +
 rtl/mul_seq_8bits_neg_w.sv | 37 +++
 rtl/mul_seq_8bits.sv | 115 +++++++++++
 tb/tb_mul_seq_8bits.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: multiplier FSM states, default
// operand width and the 8-bit signed result limits.
package calc_pkg;

    localparam int unsigned CALC_W = 8;
    localparam int CALC_SMAX = 127;
    localparam int CALC_SMIN = -128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/mul_seq_8bits_neg_w.sv
// Ripple-carry two's-complement negate (invert plus one) built from
// full_adder cells; purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module neg_w #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);
    logic [N-1:0] c;

    assign c[0] = 1'b1;

    genvar i;
    for (i = 0; i < N - 1; i++) begin : g_fa
        full_adder u_fa (
            .a    (~a[i]),
            .b    (1'b0),
            .cin  (c[i]),
            .sum  (y[i]),
            .cout (c[i+1])
        );
    end

    // Carry out of the top bit is discarded, so the MSB needs only the sum term.
    assign y[N-1] = ~a[N-1] ^ c[N-1];
endmodule

// File: rtl/mul_seq_8bits.sv
// Sequential signed WxW shift-add multiplier with start/busy/done handshake.
// Define MUL_EARLY_TERM_EN to leave RUN once the multiplier magnitude is exhausted.
module mul_seq_8bits
    import calc_pkg::*;
#(
    parameter int unsigned W          = CALC_W,
    parameter int unsigned ITER_CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic           ovf
);
    localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(W - 1);
    localparam logic signed [2*W-1:0] P_MAX = (2*W)'(CALC_SMAX);
    localparam logic signed [2*W-1:0] P_MIN = (2*W)'(CALC_SMIN);

    state_t                state;
    logic [W-1:0]          mcand;
    logic [W-1:0]          mplier;
    logic [2*W-1:0]        acc;
    logic [ITER_CNT_W-1:0] cnt;
    logic                  sign;

    logic [W-1:0]          mcand_neg;
    logic [W-1:0]          mplier_neg;
    logic [W:0]            add_sum;
    logic [2*W-1:0]        acc_next;
    logic [2*W-1:0]        acc_fix;
    logic [2*W-1:0]        acc_neg;
    logic signed [2*W-1:0] prod_next;
    logic                  ovf_next;

    neg_w #(.N(W))   u_neg_a   (.a(mcand),   .y(mcand_neg));
    neg_w #(.N(W))   u_neg_b   (.a(mplier),  .y(mplier_neg));
    neg_w #(.N(2*W)) u_neg_acc (.a(acc_fix), .y(acc_neg));

    assign add_sum  = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
    assign acc_next = {add_sum, acc[W-1:1]};

`ifdef MUL_EARLY_TERM_EN
    // cnt holds the shifts already applied; finish the skipped ones here.
    assign acc_fix = acc >> (ITER_CNT_W'(W) - cnt);
`else
    assign acc_fix = acc;
`endif

    assign prod_next = sign ? acc_neg : acc_fix;
    assign ovf_next  = (prod_next > P_MAX) || (prod_next < P_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        sign   <= op_a[W-1] ^ op_b[W-1];
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    mcand  <= mcand[W-1]  ? mcand_neg  : mcand;
                    mplier <= mplier[W-1] ? mplier_neg : mplier;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
`ifdef MUL_EARLY_TERM_EN
                    if (cnt == LAST_ITER || mplier[W-1:1] == '0)
                        state <= FIX;
`else
                    if (cnt == LAST_ITER)
                        state <= FIX;
`endif
                end
                FIX: begin
                    product <= prod_next;
                    ovf     <= ovf_next;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_8bits.sv
// Self-checking bench for mul_seq_8bits: directed table, handshake corner
// sequences and randomized operands against an integer-arithmetic model.
module tb_mul_seq_8bits;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    mul_seq_8bits #(.W(8), .ITER_CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic        ov;
        int          inj;
    } vec_t;

    vec_t tbl[12];

    function automatic int sx8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Edges from the accepting edge to the edge that raises done.
    function automatic int lat_of(input logic [7:0] b);
`ifdef MUL_EARLY_TERM_EN
        int mag;
        int bits;
        mag  = (sx8(b) < 0) ? -sx8(b) : sx8(b);
        bits = 0;
        while (mag != 0) begin
            bits++;
            mag = mag / 2;
        end
        if (bits == 0) bits = 1;
        return 2 + bits;
`else
        return 10;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after the accepting edge; follows the operation to done.
    task automatic finish_op(input logic [7:0] b, input logic [15:0] exp_p,
                             input logic exp_ov, input int inj);
        int n;
        int busy_cnt;
        bit got;
        int lat;
        lat      = lat_of(b);
        n        = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && n <= 20) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
                start = (inj != 0 && n + 1 == inj);
                op_a  = 8'($urandom);
                op_b  = 8'($urandom);
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", n, lat);
        check("busy_cycles", busy_cnt, lat);
        check("busy_at_done", 32'(busy), 32'd0);
        check("product", 32'(product), 32'(exp_p));
        check("ovf", 32'(ovf), 32'(exp_ov));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("product_held", 32'(product), 32'(exp_p));
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input logic exp_ov, input int inj);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_start", 32'(busy), 32'd1);
        finish_op(b, exp_p, exp_ov, inj);
    endtask

    task automatic model_op(input logic [7:0] a, input logic [7:0] b);
        int p;
        logic [15:0] pv;
        p  = sx8(a) * sx8(b);
        pv = p[15:0];
        do_op(a, b, pv, (p > 127) || (p < -128), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'h07, 8'h06, 16'h002A, 1'b0, 0};
        tbl[1]  = '{8'hFD, 8'h05, 16'hFFF1, 1'b0, 0};
        tbl[2]  = '{8'h80, 8'h80, 16'h4000, 1'b1, 0};
        tbl[3]  = '{8'h80, 8'h01, 16'hFF80, 1'b0, 0};
        tbl[4]  = '{8'h00, 8'h9C, 16'h0000, 1'b0, 0};
        tbl[5]  = '{8'h7F, 8'h7F, 16'h3F01, 1'b1, 0};
        tbl[6]  = '{8'hFF, 8'hFF, 16'h0001, 1'b0, 0};
        tbl[7]  = '{8'h80, 8'h7F, 16'hC080, 1'b1, 0};
        tbl[8]  = '{8'hF0, 8'h08, 16'hFF80, 1'b0, 0};
        tbl[9]  = '{8'h10, 8'h08, 16'h0080, 1'b1, 0};
        tbl[10] = '{8'h05, 8'h81, 16'hFD85, 1'b1, 5};
        tbl[11] = '{8'h22, 8'h7E, 16'h10BC, 1'b1, 9};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].ov, tbl[i].inj);

        // Start held through DONE must be ignored there and taken in the next IDLE.
        @(negedge clk);
        op_a  = 8'h07;
        op_b  = 8'h06;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("chain_first_done", 32'(done), 32'd1);
        check("chain_first_product", 32'(product), 32'h002A);
        @(negedge clk);
        op_a  = 8'hFD;
        op_b  = 8'h05;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("start_after_done_taken", 32'(busy), 32'd1);
        finish_op(8'h05, 16'hFFF1, 1'b0, 0);

        // Reset in RUN cycle 4 aborts and clears everything.
        @(negedge clk);
        op_a  = 8'h13;
        op_b  = 8'h85;
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dcount;
            dcount = 0;
            repeat (15) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) dcount++;
            end
            check("abort_no_done", dcount, 0);
            check("abort_product_stays", 32'(product), 32'd0);
        end
        do_op(8'hFD, 8'h05, 16'hFFF1, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: a = 8'h80;
                1: b = 8'h80;
                2: b = 8'h00;
                3: a = 8'h7F;
                4: b = 8'h01;
                default: ;
            endcase
            model_op(a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
